// File: rtl/vn_serial_acc.sv
// vn_serial_acc -- serial LDPC variable-node update.
//
// A frame arrives as deg+1 sign-magnitude beats on the input stream.
// Beat 0 is the channel LLR and beats 1..deg are the check-to-variable
// messages in edge order. The node sums everything into a wide signed
// accumulator. It then emits deg extrinsic messages (total minus the
// message received on that edge), saturated back to W-bit
// sign-magnitude.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   cfg_deg       node degree, sampled with beat 0 (0, 1 or >DEG_MAX -> DEG_MAX)
//   in_valid/in_ready/in_data     input beat stream
//   out_valid/out_ready/out_data  extrinsic message stream
//   out_idx       0-based edge index of out_data
//   out_last      high on the final extrinsic message of the frame
//   sum_out       saturated a-posteriori total (sign-magnitude)
//   hard_bit      1 when the total is negative
//   busy          high while accumulating or emitting
//   dbg_state     current FSM state (0 IDLE, 1 ACC, 2 EMIT)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Valid never waits on ready. Once out_valid is raised, the payload
// holds until it is accepted.
module vn_serial_acc #(
   parameter  int W       = 4,
   parameter  int DEG_MAX = 4,
   localparam int DW      = $clog2(DEG_MAX + 1),
   localparam int AW      = W + DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] cfg_deg,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [DW-1:0] out_idx,
   output logic          out_last,
   output logic [W-1:0]  sum_out,
   output logic          hard_bit,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   localparam int IW = $clog2(DEG_MAX);
   localparam logic [DW-1:0]        DEG_MAX_W = DW'(DEG_MAX);
   localparam logic signed [AW-1:0] MAX_MAG   = AW'((2 ** (W - 1)) - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   // Sign-magnitude to two's complement; negative zero becomes 0.
   function automatic logic signed [AW-1:0] sm_to_tc(input logic [W-1:0] x);
      logic signed [AW-1:0] mag;
      mag = {{(AW - W + 1){1'b0}}, x[W-2:0]};
      return x[W-1] ? -mag : mag;
   endfunction

   // Saturate to +/-(2^(W-1)-1) and convert to sign-magnitude.
   // Zero comes out as positive zero.
   function automatic logic [W-1:0] tc_to_sm_sat(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] mag;
      mag = v[AW-1] ? -v : v;
      if (mag > MAX_MAG) mag = MAX_MAG;
      return {v[AW-1], mag[W-2:0]};
   endfunction

   state_t                 state_q, state_d;
   logic [DW-1:0]          deg_q, deg_d;
   logic [DW-1:0]          cnt_q, cnt_d;   // number of the next expected message
   logic [DW-1:0]          idx_q, idx_d;   // edge currently offered on out_*
   logic signed [AW-1:0]   acc_q, acc_d;
   logic [W-1:0]           sum_q, sum_d;
   logic                   hard_q, hard_d;
   logic signed [W-1:0]    buf_q [DEG_MAX];
   logic signed [W-1:0]    buf_d [DEG_MAX];

   logic                   in_hs, out_hs, last_edge;
   logic [DW-1:0]          deg_eff;
   logic signed [AW-1:0]   in_tc, ext;
   logic [IW-1:0]          wr_idx, rd_idx;
   logic signed [W-1:0]    rd_msg;

   assign in_ready  = (state_q != S_EMIT);
   assign out_valid = (state_q == S_EMIT);
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;

   assign deg_eff   = ((cfg_deg < DW'(2)) || (cfg_deg > DEG_MAX_W)) ? DEG_MAX_W : cfg_deg;
   assign in_tc     = sm_to_tc(in_data);
   assign wr_idx    = IW'(cnt_q - DW'(1));
   assign rd_idx    = IW'(idx_q);
   assign rd_msg    = buf_q[rd_idx];
   assign ext       = acc_q - {{DW{rd_msg[W-1]}}, rd_msg};
   assign last_edge = (idx_q == deg_q - DW'(1));

   // Outputs are derived from state that is frozen during EMIT,
   // so they hold while the downstream stalls.
   assign out_data  = (state_q == S_EMIT) ? tc_to_sm_sat(ext) : '0;
   assign out_idx   = idx_q;
   assign out_last  = (state_q == S_EMIT) && last_edge;
   assign sum_out   = sum_q;
   assign hard_bit  = hard_q;

   always_comb begin
      state_d = state_q;
      deg_d   = deg_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      hard_d  = hard_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: begin
            if (in_hs) begin
               state_d = S_ACC;
               deg_d   = deg_eff;
               cnt_d   = DW'(1);
               acc_d   = in_tc;
            end
         end
         S_ACC: begin
            if (in_hs) begin
               buf_d[wr_idx] = in_tc[W-1:0];
               acc_d         = acc_q + in_tc;
               if (cnt_q == deg_q) begin
                  // sum_out/hard_bit change only here, so they stay put
                  // through IDLE and the next frame's accumulation.
                  state_d = S_EMIT;
                  idx_d   = '0;
                  sum_d   = tc_to_sm_sat(acc_d);
                  hard_d  = acc_d[AW-1];
               end else begin
                  cnt_d = cnt_q + DW'(1);
               end
            end
         end
         S_EMIT: begin
            if (out_hs) begin
               if (last_edge) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + DW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         deg_q   <= DEG_MAX_W;
         cnt_q   <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         hard_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         deg_q   <= deg_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         hard_q  <= hard_d;
      end
   end

   // The message buffer is always written before it is read within a
   // frame, so it carries no reset.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

endmodule

// File: tb/tb_vn_serial_acc.sv
// Directed bench for vn_serial_acc (W=4, DEG_MAX=4).
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled on the falling edge.
module tb_vn_serial_acc;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] cfg_deg;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [2:0] out_idx;
   logic       out_last;
   logic [3:0] sum_out;
   logic       hard_bit;
   logic       busy;
   logic [1:0] dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] exp_q[$];
   logic [3:0] exp_sum;
   logic       exp_hard;
   logic [3:0] prev_sum;
   logic       prev_hard;

   always #5 clk = ~clk;

   vn_serial_acc #(.W(4), .DEG_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_deg   (cfg_deg),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .sum_out   (sum_out),
      .hard_bit  (hard_bit),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   task automatic check_reset_values(input string tag);
      n_cmp++;
      if ({in_ready, out_valid, out_last, out_idx, out_data, sum_out, hard_bit, busy, dbg_state}
          !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0}) begin
         n_err++;
         $display("FAIL %s reset outputs: rdy=%b ov=%b last=%b idx=%0d data=%h sum=%h hb=%b busy=%b st=%0d",
                  tag, in_ready, out_valid, out_last, out_idx, out_data, sum_out, hard_bit, busy, dbg_state);
      end
      prev_sum  = 4'd0;
      prev_hard = 1'b0;
      exp_q.delete();
   endtask

   // Drives n beats. Beats after beat 0 carry a junk cfg_deg, which the
   // DUT must ignore. Between beats there are gap idle cycles of junk data.
   task automatic drive_frame(input logic [2:0] deg, input int n, input int gap,
                              input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                              input logic [3:0] b3, input logic [3:0] b4);
      logic [3:0] beats [5];
      beats = '{b0, b1, b2, b3, b4};
      for (int b = 0; b < n; b++) begin
         cfg_deg  = (b == 0) ? deg : 3'(b + 1);
         in_data  = beats[b];
         in_valid = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drive beat%0d: in_ready=%b out_valid=%b want 1/0", b, in_ready, out_valid);
         end
         n_cmp++;
         if (sum_out !== prev_sum || hard_bit !== prev_hard) begin
            n_err++;
            $display("FAIL sum_hold beat%0d: sum=%h hb=%b want %h/%b", b, sum_out, hard_bit, prev_sum, prev_hard);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (b != n - 1) begin
            for (int g = 0; g < gap; g++) begin
               in_data = 4'($urandom_range(0, 15));
               cfg_deg = 3'($urandom_range(0, 7));
               @(posedge clk); #1;
            end
         end
      end
      // The first output must be offered right after the last handshake.
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL first_out_latency: out_valid=%b want 1", out_valid);
      end
   endtask

   // Consumes `take` messages of a frame of degree deg. Message stall_at is
   // held with out_ready=0 for stall_len cycles first.
   task automatic collect(input int deg, input int take, input int stall_at, input int stall_len);
      logic [3:0] e;
      for (int i = 0; i < take; i++) begin
         e = exp_q.pop_front();
         if (i == stall_at) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               @(negedge clk);
               n_cmp++;
               if (out_valid !== 1'b1 || out_data !== e || out_idx !== 3'(i) || in_ready !== 1'b0) begin
                  n_err++;
                  $display("FAIL stall idx%0d cyc%0d: ov=%b data=%h idx=%0d rdy=%b want 1/%h/%0d/0",
                           i, s, out_valid, out_data, out_idx, in_ready, e, i);
               end
               @(posedge clk); #1;
            end
         end
         out_ready = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== e || out_idx !== 3'(i)) begin
            n_err++;
            $display("FAIL out idx%0d: ov=%b data=%h idx=%0d want 1/%h/%0d", i, out_valid, out_data, out_idx, e, i);
         end
         n_cmp++;
         if (out_last !== (i == deg - 1)) begin
            n_err++;
            $display("FAIL out_last idx%0d: got %b want %b", i, out_last, (i == deg - 1));
         end
         n_cmp++;
         if (sum_out !== exp_sum || hard_bit !== exp_hard || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL emit_status idx%0d: sum=%h hb=%b rdy=%b busy=%b want %h/%b/0/1",
                     i, sum_out, hard_bit, in_ready, busy, exp_sum, exp_hard);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      if (take == deg) begin
         n_cmp++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum_out !== exp_sum || hard_bit !== exp_hard) begin
            n_err++;
            $display("FAIL frame_end: rdy=%b ov=%b busy=%b sum=%h hb=%b want 1/0/0/%h/%b",
                     in_ready, out_valid, busy, sum_out, hard_bit, exp_sum, exp_hard);
         end
         prev_sum  = exp_sum;
         prev_hard = exp_hard;
      end
   endtask

   task automatic expect_frame(input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2,
                               input logic [3:0] e3, input int deg, input logic [3:0] s, input logic h);
      logic [3:0] ev [4];
      ev = '{e0, e1, e2, e3};
      exp_q.delete();
      for (int i = 0; i < deg; i++) exp_q.push_back(ev[i]);
      exp_sum  = s;
      exp_hard = h;
   endtask

   task automatic nominal(input logic [2:0] deg, input int gap, input int stall_at, input int stall_len);
      expect_frame(4'h3, 4'h1, 4'h6, 4'h4, 4, 4'h4, 1'b0);
      drive_frame(deg, 5, gap, 4'h2, 4'h1, 4'h3, 4'hA, 4'h8);
      collect(4, 4, stall_at, stall_len);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; in_data = 4'h0; cfg_deg = 3'd4;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("power_on");
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      nominal(3'd4, 0, -1, 0);
   endtask

   task automatic test_saturation();
      expect_frame(4'h7, 4'h7, 4'h7, 4'h7, 4, 4'h7, 1'b0);
      drive_frame(3'd4, 5, 0, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7);
      collect(4, 4, -1, 0);
      expect_frame(4'hF, 4'hF, 4'hF, 4'hF, 4, 4'hF, 1'b1);
      drive_frame(3'd4, 5, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
      collect(4, 4, -1, 0);
   endtask

   task automatic test_degree();
      // total = 0+5-3 = 2; extrinsics 2-5=-3, 2+3=5
      expect_frame(4'hB, 4'h5, 4'h0, 4'h0, 2, 4'h2, 1'b0);
      drive_frame(3'd2, 3, 0, 4'h0, 4'h5, 4'hB, 4'h0, 4'h0);
      collect(2, 2, -1, 0);
      // degree 3: 1+2+3-1 = 5; extrinsics 3, 2, 6
      expect_frame(4'h3, 4'h2, 4'h6, 4'h0, 3, 4'h5, 1'b0);
      drive_frame(3'd3, 4, 0, 4'h1, 4'h2, 4'h3, 4'h9, 4'h0);
      collect(3, 3, -1, 0);
      // out-of-range degrees fall back to 4
      nominal(3'd0, 0, -1, 0);
      nominal(3'd1, 0, -1, 0);
      nominal(3'd6, 0, -1, 0);
   endtask

   task automatic test_backpressure();
      nominal(3'd4, 0, 1, 3);
   endtask

   task automatic test_gaps();
      nominal(3'd4, 2, -1, 0);
   endtask

   task automatic test_negative_total();
      // total = -3-2+0+1-1 = -5; extrinsics -3, -5, -6, -4
      expect_frame(4'hB, 4'hD, 4'hE, 4'hC, 4, 4'hD, 1'b1);
      drive_frame(3'd4, 5, 1, 4'hB, 4'hA, 4'h8, 4'h1, 4'h9);
      collect(4, 4, 2, 1);
   endtask

   task automatic test_reset_mid();
      // Interrupt accumulation after two beats.
      drive_frame_partial();
      rst = 1'b1;
      #1;
      check_reset_values("mid_acc");
      @(posedge clk); #1;
      rst = 1'b0;
      nominal(3'd4, 0, -1, 0);
      // Interrupt emission at edge 2.
      expect_frame(4'h3, 4'h1, 4'h6, 4'h4, 4, 4'h4, 1'b0);
      drive_frame(3'd4, 5, 0, 4'h2, 4'h1, 4'h3, 4'hA, 4'h8);
      collect(4, 2, -1, 0);
      n_cmp++;
      if (out_idx !== 3'd2 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_idx: idx=%0d ov=%b want 2/1", out_idx, out_valid);
      end
      rst = 1'b1;
      #1;
      check_reset_values("mid_emit");
      @(posedge clk); #1;
      rst = 1'b0;
      nominal(3'd4, 0, -1, 0);
   endtask

   task automatic drive_frame_partial();
      for (int b = 0; b < 2; b++) begin
         cfg_deg  = 3'd2;
         in_data  = 4'h7;
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || dbg_state !== 2'd1) begin
         n_err++;
         $display("FAIL partial_acc: busy=%b state=%0d want 1/1", busy, dbg_state);
      end
   endtask

   initial begin
      prev_sum = 4'd0;
      prev_hard = 1'b0;
      test_reset();
      test_nominal();
      test_saturation();
      test_degree();
      test_backpressure();
      test_gaps();
      test_negative_total();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
